display_scanner: RTL and testbench

- Parametrised multi-digit scan controller for common-anode 7-segment displays.
- Generalises the fixed 8-digit, 3-bit-select scanner with:
  - any digit count;
  - an internal clock-enable prescaler, so it runs off the system clock rather than a divided clock;
  - per-digit blanking;
  - PWM brightness control.
- Drives the active-low anode bus and the digit-select index for the downstream data multiplexer.

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scanner_if.sv | 43 ++++
 rtl/display_scanner_prescaler.sv | 53 +++++
 rtl/display_scanner.sv | 136 +++++++++++++
 tb/tb_display_scanner.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared constants and helpers for the 7-segment scan
//                controller. Provides the anode-off level, a constant
//                ceil(log2) helper for elaboration-time checks, and the
//                prescale value for a 100 MHz board clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Common-anode drive is active-low: a 1 on the anode line turns it off.
    localparam logic AN_OFF = 1'b1;

    // 100 MHz / (8 digits * 16 PWM steps * 480 Hz) ~= 1628 clocks per step.
    localparam int DEFAULT_SUB_DIV = 1628;

    // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : display_pkg
`default_nettype wire

// File: rtl/display_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner_if
//  Description : Control / drive bundle of the display scanner.
//                master : block feeding enable, per-digit enables and
//                         brightness, and receiving the display drive.
//                slave  : the scanner itself.
//  Signals     : en, digit_en[NUM_DIGITS], brightness[DUTY_W]   (to scanner)
//                an[NUM_DIGITS] (active-low), seg_sel[SEL_W],
//                slot_tick                                      (from scanner)
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_scanner_if #(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = 3,
    parameter int DUTY_W     = 4
);
    logic                  en;
    logic [NUM_DIGITS-1:0] digit_en;
    logic [DUTY_W-1:0]     brightness;
    logic [NUM_DIGITS-1:0] an;
    logic [SEL_W-1:0]      seg_sel;
    logic                  slot_tick;

    modport master (
        output en,
        output digit_en,
        output brightness,
        input  an,
        input  seg_sel,
        input  slot_tick
    );

    modport slave (
        input  en,
        input  digit_en,
        input  brightness,
        output an,
        output seg_sel,
        output slot_tick
    );
endinterface : display_scanner_if
`default_nettype wire

// File: rtl/display_scanner_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : scan_prescaler
//  Description : Clock-enable prescaler for the scanner. sub_cnt divides the
//                system clock into PWM steps; step_cnt counts the steps of a
//                digit slot. Both freeze while en is low.
//  Ports       : clk, reset (async, active-high), en      - inputs
//                step_cnt[DUTY_W]  - current PWM step within the slot
//                slot_end          - high in the last enabled clock of a slot
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_prescaler #(
    parameter int SUB_DIV = 1628,
    parameter int DUTY_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [DUTY_W-1:0] step_cnt,
    output logic              slot_end
);
    // SUB_DIV = 1 still needs a 1-bit counter; it simply stays at 0.
    localparam int              SUB_W    = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);

    logic [SUB_W-1:0]  r_sub_cnt;
    logic [DUTY_W-1:0] r_step_cnt;
    logic              w_sub_last;
    logic              w_step_last;

    assign w_sub_last  = (r_sub_cnt == SUB_LAST);
    assign w_step_last = &r_step_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sub_cnt  <= '0;
            r_step_cnt <= '0;
        end else if (en) begin
            if (w_sub_last) begin
                r_sub_cnt  <= '0;
                // Step count is a power of two, so natural overflow wraps it.
                r_step_cnt <= r_step_cnt + DUTY_W'(1);
            end else begin
                r_sub_cnt  <= r_sub_cnt + SUB_W'(1);
            end
        end
    end

    assign step_cnt = r_step_cnt;
    assign slot_end = en & w_sub_last & w_step_last;

endmodule : scan_prescaler
`default_nettype wire

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Multi-digit scan controller for common-anode 7-segment
//                displays, with clock-enable prescaling, per-digit blanking
//                and PWM brightness. Brightness and the next digit's enable
//                are latched at each slot boundary so mid-slot changes never
//                glitch the display.
//  Ports       : clk            - system clock
//                reset          - asynchronous active-high reset
//                bus (slave)    - en, digit_en, brightness in;
//                                 an (active-low), seg_sel, slot_tick out
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = 3,
    parameter int SUB_DIV    = DEFAULT_SUB_DIV,
    parameter int DUTY_W     = 4
) (
    input  logic            clk,
    input  logic            reset,
    display_scanner_if.slave bus
);
    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (SEL_W < clog2(NUM_DIGITS)) begin : g_sel_w_too_narrow
        $error("display_scanner: SEL_W is too narrow for NUM_DIGITS");
    end
    if ((NUM_DIGITS < 2) || (NUM_DIGITS > 16)) begin : g_num_digits_range
        $error("display_scanner: NUM_DIGITS must be within 2..16");
    end
    if (SUB_DIV < 1) begin : g_sub_div_range
        $error("display_scanner: SUB_DIV must be at least 1");
    end

    localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [DUTY_W-1:0] w_step_cnt;
    logic              w_slot_end;

    scan_prescaler #(
        .SUB_DIV (SUB_DIV),
        .DUTY_W  (DUTY_W)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.en),
        .step_cnt (w_step_cnt),
        .slot_end (w_slot_end)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SEL_W-1:0]      r_digit_idx;
    logic [DUTY_W-1:0]     r_lat_bri;
    logic                  r_lat_den;
    logic [NUM_DIGITS-1:0] r_an;
    logic [SEL_W-1:0]      r_seg_sel;
    logic                  r_slot_tick;
    // Set by the slot-end edge; turned into slot_tick one enabled clock
    // later so the pulse lines up with the first output of the new slot.
    logic                  r_wrap;

    logic [SEL_W-1:0]      w_idx_next;
    logic                  w_den_next;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_an_next;

    // Explicit compare so non-power-of-2 digit counts wrap correctly.
    assign w_idx_next = (r_digit_idx == LAST_DIGIT) ? '0
                                                    : r_digit_idx + SEL_W'(1);

    // Enable bit of the digit about to be scanned.
    always_comb begin
        w_den_next = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_next == SEL_W'(i)) begin
                w_den_next = bus.digit_en[i];
            end
        end
    end

    assign w_lit = bus.en & r_lat_den & (w_step_cnt <= r_lat_bri);

    // At most one anode bit is ever driven on.
    always_comb begin
        w_an_next = {NUM_DIGITS{AN_OFF}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == SEL_W'(i)) begin
                w_an_next[i] = w_lit ? ~AN_OFF : AN_OFF;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit_idx <= '0;
            r_lat_bri   <= '0;
            r_lat_den   <= 1'b0;
            r_an        <= {NUM_DIGITS{AN_OFF}};
            r_seg_sel   <= '0;
            r_slot_tick <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            // slot_end is already qualified by en inside the prescaler.
            if (w_slot_end) begin
                r_digit_idx <= w_idx_next;
                r_lat_bri   <= bus.brightness;
                r_lat_den   <= w_den_next;
            end

            r_an        <= w_an_next;
            r_slot_tick <= bus.en & r_wrap;

            // seg_sel and the pending-tick flag freeze with the counters.
            if (bus.en) begin
                r_seg_sel <= r_digit_idx;
                r_wrap    <= w_slot_end;
            end
        end
    end

    assign bus.an        = r_an;
    assign bus.seg_sel   = r_seg_sel;
    assign bus.slot_tick = r_slot_tick;

endmodule : display_scanner
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Self-checking bench for display_scanner (5 digits, SUB_DIV=2,
//                DUTY_W=2, 8-clock slots). A reference model tracks the
//                number of enabled clocks since reset and derives digit,
//                PWM step and slot boundaries from it arithmetically.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;
    localparam int ND   = 5;
    localparam int SW   = 3;
    localparam int SD   = 2;
    localparam int DW   = 2;
    localparam int SLOT = SD * (1 << DW);

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    display_scanner_if #(.NUM_DIGITS(ND), .SEL_W(SW), .DUTY_W(DW)) bus ();

    display_scanner #(
        .NUM_DIGITS (ND),
        .SEL_W      (SW),
        .SUB_DIV    (SD),
        .DUTY_W     (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            c;        // enabled clocks since reset
    int            m_bri;    // brightness in force for the current slot
    logic          m_den;    // digit enable in force for the current slot
    logic [ND-1:0] exp_an;
    logic [SW-1:0] exp_sel;
    logic          exp_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_an"},   32'(bus.an),        32'(exp_an));
        chk({tag, "_sel"},  32'(bus.seg_sel),   32'(exp_sel));
        chk({tag, "_tick"}, 32'(bus.slot_tick), 32'(exp_tick));
    endtask

    task automatic model_reset();
        c        = 0;
        m_bri    = 0;
        m_den    = 1'b0;
        exp_an   = '1;
        exp_sel  = '0;
        exp_tick = 1'b0;
    endtask

    // One clock: the model consumes the inputs seen at the edge, then the
    // DUT outputs are compared 1 time unit later.
    task automatic tick(input string tag);
        int digit, step;
        @(posedge clk);
        if (bus.en) begin
            digit    = (c / SLOT) % ND;
            step     = (c % SLOT) / SD;
            exp_an   = '1;
            if (m_den && (step <= m_bri)) exp_an[digit] = 1'b0;
            exp_sel  = SW'(digit);
            exp_tick = ((c % SLOT) == 0) && (c > 0);
            if ((c % SLOT) == SLOT - 1) begin
                m_bri = int'(bus.brightness);
                m_den = bus.digit_en[((c + 1) / SLOT) % ND];
            end
            c++;
        end else begin
            exp_an   = '1;
            exp_tick = 1'b0;
        end
        #1;
        chk_outputs(tag);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_outputs("reset_hold");
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int ticks;
        int reached;

        bus.en         = 1'b0;
        bus.digit_en   = '1;
        bus.brightness = 2'd3;
        model_reset();
        do_reset();

        // Full brightness, all digits, then reset in the middle of a slot.
        bus.en = 1'b1;
        repeat (20) tick("full_on");
        do_reset();
        repeat (50) tick("after_reset");

        // Half brightness, then a mid-slot drop to minimum brightness.
        bus.brightness = 2'd1;
        repeat (28) tick("bri1");
        bus.brightness = 2'd0;
        repeat (20) tick("bri0");

        // Blank digits 1 and 3; count slot ticks across one 40-clock frame.
        bus.brightness = 2'd2;
        bus.digit_en   = 5'b10101;
        repeat (10) tick("blank_prep");
        ticks = 0;
        for (int k = 0; k < ND * SLOT; k++) begin
            tick("blank");
            if (bus.slot_tick === 1'b1) ticks++;
        end
        chk("frame_ticks", 32'(ticks), 32'(ND));

        // Drop en mid-slot while digit 2 is being scanned.
        bus.digit_en = '1;
        reached = 0;
        for (int k = 0; k < 200; k++) begin
            if (((c / SLOT) % ND == 2) && (c % SLOT == 3)) begin
                reached = 1;
                break;
            end
            tick("seek_d2");
        end
        chk("en_drop_sync", 32'(reached), 32'd1);
        bus.en = 1'b0;
        repeat (20) tick("en_low");
        chk("en_low_hold_sel", 32'(bus.seg_sel), 32'd2);
        bus.en = 1'b1;
        repeat (30) tick("en_resume");

        // Randomised operation with a reset part-way through.
        for (int k = 0; k < 800; k++) begin
            bus.en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 5) == 0) bus.digit_en   = ND'($urandom);
            if ($urandom_range(0, 5) == 0) bus.brightness = DW'($urandom);
            if (k == 400) do_reset();
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_display_scanner
`default_nettype wire
